hdmi_cfg_seq: RTL and testbench

HDMI_CFG_SEQ -- requirements
Module: hdmi_cfg_seq

---
 rtl/hdmi_cfg_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_hdmi_cfg_seq.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_cfg_seq.sv
// HDMI receiver bring-up: pulses rx_resetn, then writes a config table over I2C.
// Define HDMI_CFG_RETRY_EN to re-issue NACKed writes up to MAX_RETRY times.
module hdmi_cfg_seq #(
   parameter int RST_CYCLES  = 1000,
   parameter int WAIT_CYCLES = 2000,
   parameter int MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        hpd,
   output logic        rx_resetn,
   output logic [7:0]  tbl_addr,
   input  logic [23:0] tbl_data,
   output logic        i2c_req,
   output logic [6:0]  i2c_dev,
   output logic [7:0]  i2c_reg,
   output logic [7:0]  i2c_wdata,
   input  logic        i2c_ack,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic        busy,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [7:0]  err_index
);

   typedef enum logic [3:0] {
      IDLE, RST_ASSERT, RST_WAIT, FETCH, DECODE,
      ISSUE, WAIT_DONE, DELAY, DONE, ERROR
   } state_t;

   state_t      r_state;
   logic [31:0] r_cnt;
   logic [7:0]  r_idx;
   logic        r_rstn;
   logic        r_req;
   logic [6:0]  r_dev;
   logic [7:0]  r_reg;
   logic [7:0]  r_wdata;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [7:0]  r_err_idx;
   logic        r_hpd_s1;
   logic        r_hpd_s2;
   logic        r_hpd_d;
`ifdef HDMI_CFG_RETRY_EN
   logic [7:0]  r_retry;
`endif

   logic [7:0]  w_dev;
   logic [7:0]  w_reg;
   logic [7:0]  w_val;
   logic        w_hpd_rise;
   logic        w_last;

   assign {w_dev, w_reg, w_val} = tbl_data;
   assign w_hpd_rise = r_hpd_s2 & ~r_hpd_d;
   assign w_last     = (r_idx == 8'hFF);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hpd_s1 <= 1'b0;
         r_hpd_s2 <= 1'b0;
         r_hpd_d  <= 1'b0;
      end else begin
         r_hpd_s1 <= hpd;
         r_hpd_s2 <= r_hpd_s1;
         r_hpd_d  <= r_hpd_s2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_rstn    <= 1'b0;
         r_req     <= 1'b0;
         r_dev     <= '0;
         r_reg     <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_err_idx <= '0;
`ifdef HDMI_CFG_RETRY_EN
         r_retry   <= '0;
`endif
      end else begin
         unique case (r_state)
            IDLE, DONE, ERROR: begin
               // start wins over a coincident hpd edge
               if (start) begin
                  r_state   <= RST_ASSERT;
                  r_rstn    <= 1'b0;
                  r_cnt     <= 32'(RST_CYCLES - 1);
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_err     <= 1'b0;
                  r_err_idx <= '0;
               end else if (r_state == DONE && w_hpd_rise) begin
                  r_state <= FETCH;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            RST_ASSERT: begin
               if (r_cnt == '0) begin
                  r_rstn  <= 1'b1;
                  r_cnt   <= 32'(WAIT_CYCLES - 1);
                  r_state <= RST_WAIT;
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            RST_WAIT: begin
               if (r_cnt == '0) begin
                  r_idx   <= '0;
                  r_state <= FETCH;
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            FETCH: r_state <= DECODE;
            DECODE: begin
               if (w_dev == 8'hFF) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_dev == 8'hFE) begin
                  if (w_val != 8'd0) begin
                     r_cnt   <= {14'd0, w_val, 10'd0} - 32'd1;
                     r_state <= DELAY;
                  end else if (w_last) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + 8'd1;
                     r_state <= FETCH;
                  end
               end else begin
                  r_dev   <= w_dev[7:1];
                  r_reg   <= w_reg;
                  r_wdata <= w_val;
                  r_req   <= 1'b1;
                  r_state <= ISSUE;
`ifdef HDMI_CFG_RETRY_EN
                  r_retry <= '0;
`endif
               end
            end
            ISSUE: begin
               if (i2c_ack) begin
                  r_req   <= 1'b0;
                  r_state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i2c_done && !i2c_nack) begin
                  if (w_last) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + 8'd1;
                     r_state <= FETCH;
                  end
               end else if (i2c_done) begin
`ifdef HDMI_CFG_RETRY_EN
                  if (r_retry < 8'(MAX_RETRY)) begin
                     r_retry <= r_retry + 8'd1;
                     r_req   <= 1'b1;
                     r_state <= ISSUE;
                  end else begin
                     r_err_idx <= r_idx;
                     r_state   <= ERROR;
                     r_busy    <= 1'b0;
                     r_err     <= 1'b1;
                  end
`else
                  r_err_idx <= r_idx;
                  r_state   <= ERROR;
                  r_busy    <= 1'b0;
                  r_err     <= 1'b1;
`endif
               end
            end
            DELAY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 32'd1;
               end else if (w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + 8'd1;
                  r_state <= FETCH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rx_resetn = r_rstn;
   assign tbl_addr  = r_idx;
   assign i2c_req   = r_req;
   assign i2c_dev   = r_dev;
   assign i2c_reg   = r_reg;
   assign i2c_wdata = r_wdata;
   assign busy      = r_busy;
   assign cfg_done  = r_done;
   assign cfg_err   = r_err;
   assign err_index = r_err_idx;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Directed bench for hdmi_cfg_seq: table ROM model, I2C responder, scenario tasks.
// Build with HDMI_CFG_RETRY_EN to check the retry variant.
module tb_hdmi_cfg_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        hpd = 1'b0;
   logic        rx_resetn;
   logic [7:0]  tbl_addr;
   logic [23:0] tbl_data;
   logic        i2c_req;
   logic [6:0]  i2c_dev;
   logic [7:0]  i2c_reg;
   logic [7:0]  i2c_wdata;
   logic        i2c_ack;
   logic        i2c_done;
   logic        i2c_nack;
   logic        busy;
   logic        cfg_done;
   logic        cfg_err;
   logic [7:0]  err_index;

   int checks = 0;
   int errors = 0;

   logic [23:0] mem [256];

   int          n_req = 0;
   logic [6:0]  log_dev [64];
   logic [7:0]  log_reg [64];
   logic [7:0]  log_dat [64];
   logic [7:0]  log_idx [64];
   int          log_stab [64];
   bit          log_drop [64];
   int          att [256];
   int          nack_from [256];
   int          nack_plan [256];
   int          ack_dly = 2;
   int          done_dly = 2;

   int          rst_low;
   int          rx_low;
   int          addr_cyc [256];
   int          req_at [256];

   hdmi_cfg_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .hpd       (hpd),
      .rx_resetn (rx_resetn),
      .tbl_addr  (tbl_addr),
      .tbl_data  (tbl_data),
      .i2c_req   (i2c_req),
      .i2c_dev   (i2c_dev),
      .i2c_reg   (i2c_reg),
      .i2c_wdata (i2c_wdata),
      .i2c_ack   (i2c_ack),
      .i2c_done  (i2c_done),
      .i2c_nack  (i2c_nack),
      .busy      (busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .err_index (err_index)
   );

   always #5 clk = ~clk;

   // synchronous table ROM: data valid the cycle after the address
   always @(posedge clk) tbl_data <= mem[tbl_addr];

   // I2C master model: ack after ack_dly cycles, done done_dly cycles later
   initial begin : responder
      int k;
      int s;
      bit bad;
      logic [7:0] ix;
      i2c_ack = 1'b0;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      forever begin
         @(negedge clk);
         if (i2c_req === 1'b1) begin
            k = n_req % 64;
            ix = tbl_addr;
            log_dev[k] = i2c_dev;
            log_reg[k] = i2c_reg;
            log_dat[k] = i2c_wdata;
            log_idx[k] = ix;
            s = 0;
            repeat (ack_dly) begin
               @(negedge clk);
               if (i2c_req === 1'b1 && i2c_dev === log_dev[k] &&
                   i2c_reg === log_reg[k] && i2c_wdata === log_dat[k])
                  s++;
            end
            i2c_ack = 1'b1;
            @(negedge clk);
            i2c_ack = 1'b0;
            log_stab[k] = s;
            log_drop[k] = (i2c_req === 1'b0);
            bad = (att[ix] - nack_from[ix]) < nack_plan[ix];
            att[ix]++;
            n_req++;
            repeat (done_dly - 1) @(negedge clk);
            i2c_done = 1'b1;
            i2c_nack = bad;
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 24'hFF0000;
   endtask

   task automatic load_basic();
      clear_mem();
      mem[0] = 24'h721011;
      mem[1] = 24'h722022;
      mem[2] = 24'h983033;
      mem[3] = 24'hFF0000;
   endtask

   task automatic load_delay();
      clear_mem();
      mem[0] = 24'h721011;
      mem[1] = 24'hFE0002;
      mem[2] = 24'h722022;
      mem[3] = 24'hFE0000;
      mem[4] = 24'h983033;
      mem[5] = 24'hFF0000;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_seq(input int bound, output bit to);
      int base;
      to = 1'b1;
      rst_low = 0;
      rx_low = 0;
      base = n_req;
      for (int i = 0; i < 256; i++) begin
         addr_cyc[i] = 0;
         req_at[i] = 0;
      end
      for (int c = 0; c < bound; c++) begin
         @(negedge clk);
         if (busy && !rx_resetn) rst_low++;
         if (!rx_resetn) rx_low++;
         if (n_req != base) begin
            addr_cyc[tbl_addr]++;
            if (i2c_req) req_at[tbl_addr]++;
         end
         if (!busy && (cfg_done || cfg_err)) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (rx_resetn !== 1'b0) begin
         errors++; $display("FAIL reset_rx_resetn: got %b want 0", rx_resetn);
      end
      checks++;
      if (i2c_req !== 1'b0) begin
         errors++; $display("FAIL reset_i2c_req: got %b want 0", i2c_req);
      end
      checks++;
      if ({busy, cfg_done, cfg_err} !== 3'b000) begin
         errors++; $display("FAIL reset_status: got %b want 000", {busy, cfg_done, cfg_err});
      end
      checks++;
      if ({err_index, tbl_addr} !== 16'h0000) begin
         errors++; $display("FAIL reset_idx: got %h want 0000", {err_index, tbl_addr});
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({busy, rx_resetn} !== 2'b00) begin
         errors++; $display("FAIL idle_hold: got %b want 00", {busy, rx_resetn});
      end
   endtask

   task automatic test_basic();
      bit to;
      int b;
      int k;
      logic [23:0] exp [3];
      exp[0] = 24'h391011;
      exp[1] = 24'h392022;
      exp[2] = 24'h4C3033;
      load_basic();
      ack_dly = 2;
      done_dly = 2;
      b = n_req;
      pulse_start();
      run_seq(20000, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL basic_timeout: got busy=%b want done", busy);
      end
      checks++;
      if (rst_low != 1000) begin
         errors++; $display("FAIL basic_rst_low: got %0d want 1000", rst_low);
      end
      checks++;
      if (n_req - b != 3) begin
         errors++; $display("FAIL basic_nreq: got %0d want 3", n_req - b);
      end
      for (int i = 0; i < 3; i++) begin
         k = (b + i) % 64;
         checks++;
         if ({1'b0, log_dev[k], log_reg[k], log_dat[k]} !== exp[i]) begin
            errors++;
            $display("FAIL basic_req%0d: got %h want %h", i,
                     {1'b0, log_dev[k], log_reg[k], log_dat[k]}, exp[i]);
         end
      end
      checks++;
      if ({cfg_done, cfg_err, rx_resetn} !== 3'b101) begin
         errors++; $display("FAIL basic_status: got %b want 101", {cfg_done, cfg_err, rx_resetn});
      end
      checks++;
      if (tbl_addr !== 8'd3) begin
         errors++; $display("FAIL basic_tbl_addr: got %0d want 3", tbl_addr);
      end
   endtask

   task automatic test_ack_hold();
      bit to;
      int b;
      clear_mem();
      mem[0] = 24'h721011;
      ack_dly = 50;
      b = n_req;
      pulse_start();
      run_seq(20000, to);
      checks++;
      if (to || n_req - b != 1) begin
         errors++; $display("FAIL hold_run: got to=%b n=%0d want 0/1", to, n_req - b);
      end
      checks++;
      if (log_stab[b % 64] != 50) begin
         errors++; $display("FAIL hold_stable: got %0d want 50", log_stab[b % 64]);
      end
      checks++;
      if (log_drop[b % 64] !== 1'b1) begin
         errors++; $display("FAIL hold_drop: got %b want 1", log_drop[b % 64]);
      end
      ack_dly = 2;
   endtask

   task automatic test_nack();
      bit to;
      int b;
      load_basic();
      nack_from[1] = att[1];
      nack_plan[1] = 2;
      b = n_req;
      pulse_start();
      run_seq(20000, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL nack_timeout: got busy=%b want idle", busy);
      end
`ifdef HDMI_CFG_RETRY_EN
      checks++;
      if (n_req - b != 5) begin
         errors++; $display("FAIL nack_nreq: got %0d want 5", n_req - b);
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (log_idx[(b + i) % 64] !== 8'd1) begin
            errors++; $display("FAIL nack_retry_idx%0d: got %0d want 1", i, log_idx[(b + i) % 64]);
         end
      end
      checks++;
      if ({cfg_done, cfg_err} !== 2'b10) begin
         errors++; $display("FAIL nack_retry_done: got %b want 10", {cfg_done, cfg_err});
      end
      nack_from[1] = att[1];
      nack_plan[1] = 4;
      b = n_req;
      pulse_start();
      run_seq(20000, to);
      checks++;
      if (to || n_req - b != 5) begin
         errors++; $display("FAIL nack_exhaust: got to=%b n=%0d want 0/5", to, n_req - b);
      end
`else
      checks++;
      if (n_req - b != 2) begin
         errors++; $display("FAIL nack_nreq: got %0d want 2", n_req - b);
      end
`endif
      checks++;
      if ({cfg_done, cfg_err} !== 2'b01 || err_index !== 8'd1) begin
         errors++;
         $display("FAIL nack_err: got %b idx=%0d want 01 idx=1", {cfg_done, cfg_err}, err_index);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (err_index !== 8'd1 || cfg_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL nack_hold: got idx=%0d err=%b want 1/1", err_index, cfg_err);
      end
      nack_plan[1] = 0;
   endtask

   task automatic test_delay();
      bit to;
      int b;
      load_delay();
      b = n_req;
      pulse_start();
      run_seq(20000, to);
      checks++;
      if (to || n_req - b != 3) begin
         errors++; $display("FAIL delay_run: got to=%b n=%0d want 0/3", to, n_req - b);
      end
      checks++;
      if (addr_cyc[1] != 2050) begin
         errors++; $display("FAIL delay_len: got %0d want 2050", addr_cyc[1]);
      end
      checks++;
      if (req_at[1] != 0) begin
         errors++; $display("FAIL delay_req: got %0d want 0", req_at[1]);
      end
      checks++;
      if (addr_cyc[3] != 2) begin
         errors++; $display("FAIL delay_zero: got %0d want 2", addr_cyc[3]);
      end
      checks++;
      if (cfg_done !== 1'b1 || tbl_addr !== 8'd5) begin
         errors++; $display("FAIL delay_done: got %b/%0d want 1/5", cfg_done, tbl_addr);
      end
   endtask

   task automatic test_hpd_restart();
      bit to;
      bit seen;
      int b;
      seen = 1'b0;
      hpd = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL hpd_restart: got busy=0 want 1");
      end
      b = n_req;
      run_seq(20000, to);
      checks++;
      if (to || rx_low != 0) begin
         errors++; $display("FAIL hpd_rx_resetn: got to=%b low=%0d want 0/0", to, rx_low);
      end
      checks++;
      if (n_req - b != 3 || log_idx[b % 64] !== 8'd0) begin
         errors++; $display("FAIL hpd_rerun: got n=%0d idx=%0d want 3/0", n_req - b, log_idx[b % 64]);
      end
      checks++;
      if (cfg_done !== 1'b1) begin
         errors++; $display("FAIL hpd_done: got %b want 1", cfg_done);
      end
   endtask

   task automatic test_hpd_busy();
      bit to;
      int b;
      int bc;
      hpd = 1'b0;
      repeat (5) @(negedge clk);
      b = n_req;
      pulse_start();
      repeat (100) @(negedge clk);
      hpd = 1'b1;
      run_seq(20000, to);
      checks++;
      if (to || rst_low != 900) begin
         errors++; $display("FAIL hpdbusy_rst: got to=%b low=%0d want 0/900", to, rst_low);
      end
      checks++;
      if (n_req - b != 3 || cfg_done !== 1'b1) begin
         errors++; $display("FAIL hpdbusy_run: got n=%0d done=%b want 3/1", n_req - b, cfg_done);
      end
      bc = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) bc++;
      end
      checks++;
      if (bc != 0) begin
         errors++; $display("FAIL hpdbusy_late: got busy %0d cycles want 0", bc);
      end
   endtask

   task automatic test_precedence();
      bit to;
      hpd = 1'b0;
      repeat (5) @(negedge clk);
      hpd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, rx_resetn} !== 2'b10) begin
         errors++; $display("FAIL prec_state: got %b want 10", {busy, rx_resetn});
      end
      run_seq(20000, to);
      checks++;
      if (to || rst_low != 999 || cfg_done !== 1'b1) begin
         errors++; $display("FAIL prec_run: got to=%b low=%0d want 0/999", to, rst_low);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int b;
      int qc;
      done_dly = 40;
      seen = 1'b0;
      b = n_req;
      pulse_start();
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (n_req != b) begin
            seen = 1'b1;
            break;
         end
      end
      repeat (5) @(negedge clk);
      checks++;
      if (!seen || {busy, rx_resetn} !== 2'b11) begin
         errors++; $display("FAIL rmid_pre: got seen=%b st=%b want 1/11", seen, {busy, rx_resetn});
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({rx_resetn, i2c_req, busy, cfg_done, cfg_err} !== 5'b00000) begin
         errors++;
         $display("FAIL rmid_outs: got %b want 00000", {rx_resetn, i2c_req, busy, cfg_done, cfg_err});
      end
      checks++;
      if ({err_index, tbl_addr} !== 16'h0000) begin
         errors++; $display("FAIL rmid_idx: got %h want 0000", {err_index, tbl_addr});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      qc = 0;
      repeat (200) begin
         @(negedge clk);
         if (i2c_req) qc++;
      end
      checks++;
      if (qc != 0 || n_req - b != 1) begin
         errors++; $display("FAIL rmid_quiet: got req=%0d n=%0d want 0/1", qc, n_req - b);
      end
      checks++;
      if ({busy, rx_resetn} !== 2'b00) begin
         errors++; $display("FAIL rmid_idle: got %b want 00", {busy, rx_resetn});
      end
      done_dly = 2;
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_basic();
      test_ack_hold();
      test_nack();
      test_delay();
      test_hpd_restart();
      test_hpd_busy();
      test_precedence();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
